led_blink_driver: RTL and testbench

//   Output-side counterpart to the button debouncer. It turns single-cycle

---
 rtl/led_blink_driver_if.sv | 33 +++
 rtl/led_blink_driver.sv | 127 ++++++++++++
 tb/tb_led_blink_driver.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_driver_if.sv
// Signal bundle between core logic and the LED blink driver.
// The master side (core logic) drives the requests; the slave side is the driver.
interface led_blink_driver_if #(
    parameter int unsigned PEND_W = 4
);
    logic              event_pulse;
    logic              level_in;
    logic              led;
    logic              busy;
    logic              blink_done;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output event_pulse,
        output level_in,
        input  led,
        input  busy,
        input  blink_done,
        input  pending,
        input  overflow
    );

    modport slave (
        input  event_pulse,
        input  level_in,
        output led,
        output busy,
        output blink_done,
        output pending,
        output overflow
    );
endinterface

// File: rtl/led_blink_driver.sv
// Turns single-cycle event pulses into timed LED blinks (inverted ON phase,
// level OFF gap), queueing events that arrive mid-blink in a saturating counter.
module led_blink_driver #(
    parameter int unsigned ON_CYCLES  = 50000,
    parameter int unsigned OFF_CYCLES = 50000,
    parameter int unsigned CNT_W      = 18,
    parameter int unsigned PEND_W     = 4
) (
    input  logic                clock,
    input  logic                reset,
    led_blink_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t            r_state;
    logic [CNT_W-1:0]  r_timer;
    logic              r_led;
    logic              r_busy;
    logic              r_done;
    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;

    state_t            w_state_n;
    logic [CNT_W-1:0]  w_timer_n;
    logic              w_led_n;
    logic              w_done_n;
    logic [PEND_W-1:0] w_pend_n;
    logic              w_ovf_n;
    logic              w_inc;
    logic              w_dec;

    always_comb begin
        w_state_n = r_state;
        w_timer_n = '0;
        w_done_n  = 1'b0;
        w_pend_n  = r_pending;
        w_ovf_n   = r_overflow;
        w_inc     = 1'b0;
        w_dec     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.event_pulse) begin
                    w_state_n = ST_ON;
                end
            end
            ST_ON: begin
                w_inc = bus.event_pulse;
                if (r_timer == ON_LAST) begin
                    w_state_n = ST_OFF;
                end else begin
                    w_timer_n = r_timer + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (r_timer == OFF_LAST) begin
                    w_done_n = 1'b1;
                    // A queued blink takes priority; a same-cycle event then
                    // refills the slot. With an empty queue the event restarts directly.
                    if (r_pending != '0) begin
                        w_dec     = 1'b1;
                        w_inc     = bus.event_pulse;
                        w_state_n = ST_ON;
                    end else if (bus.event_pulse) begin
                        w_state_n = ST_ON;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end else begin
                    w_inc     = bus.event_pulse;
                    w_timer_n = r_timer + CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        if (w_inc && !w_dec) begin
            if (r_pending == PEND_MAX) begin
                w_ovf_n = 1'b1;
            end else begin
                w_pend_n = r_pending + PEND_W'(1);
            end
        end else if (w_dec && !w_inc) begin
            w_pend_n = r_pending - PEND_W'(1);
        end

        w_led_n = (w_state_n == ST_ON) ? ~bus.level_in : bus.level_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_timer    <= w_timer_n;
            r_led      <= w_led_n;
            r_busy     <= (w_state_n != ST_IDLE);
            r_done     <= w_done_n;
            r_pending  <= w_pend_n;
            r_overflow <= w_ovf_n;
        end
    end

    assign bus.led        = r_led;
    assign bus.busy       = r_busy;
    assign bus.blink_done = r_done;
    assign bus.pending    = r_pending;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver: directed scenarios plus random traffic, all
// checked against a blink-position reference model.
module tb_led_blink_driver;

    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int PW   = 2;
    localparam int PMAX = 3;
    localparam int LEN  = ON + OFF;

    logic clock = 1'b0;
    logic reset = 1'b0;

    led_blink_driver_if #(.PEND_W(PW)) bus ();

    led_blink_driver #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .CNT_W     (8),
        .PEND_W    (PW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the current blink (0..LEN-1)
    bit   m_active;
    int   m_pos;
    int   m_pend;
    bit   m_ovf;
    bit   m_done;
    bit   m_led;
    logic [5:0] m_exp;

    wire [5:0] w_act = {bus.led, bus.busy, bus.blink_done, bus.pending, bus.overflow};

    task automatic tick(input logic ev, input logic lvl, input logic rs);
        bus.event_pulse = ev;
        bus.level_in    = lvl;
        reset           = rs;
        @(posedge clock);
        if (rs) begin
            m_active = 0; m_pos = 0; m_pend = 0; m_ovf = 0; m_done = 0;
        end else if (!m_active) begin
            m_done = 0;
            if (ev) begin
                m_active = 1;
                m_pos    = 0;
            end
        end else begin
            m_done = (m_pos == LEN - 1);
            if (m_pos == LEN - 1) begin
                m_pos = 0;
                if (m_pend > 0) begin
                    if (!ev) m_pend--;
                end else if (!ev) begin
                    m_active = 0;
                end
            end else begin
                m_pos++;
                if (ev) begin
                    if (m_pend < PMAX) m_pend++;
                    else m_ovf = 1;
                end
            end
        end
        m_led = rs ? 1'b0 : ((m_active && m_pos < ON) ? ~lvl : lvl);
        m_exp = {m_led, m_active, m_done, m_pend[PW-1:0], m_ovf};
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (w_act !== 6'b0) begin
            failures++;
            $display("FAIL reset: got %b expected %b", w_act, 6'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_blink();
        int n_led = 0, n_busy = 0, n_done = 0;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) tick(1'b0, 1'b0, 1'b0);
            n_led  += int'(bus.led);
            n_busy += int'(bus.busy);
            n_done += int'(bus.blink_done);
            checks++;
            if (w_act !== m_exp) begin
                failures++;
                $display("FAIL single_blink cyc%0d: got %b expected %b", i, w_act, m_exp);
            end
        end
        checks++;
        if (n_led != ON || n_busy != LEN || n_done != 1) begin
            failures++;
            $display("FAIL single_blink_counts: got led=%0d busy=%0d done=%0d expected %0d %0d 1",
                     n_led, n_busy, n_done, ON, LEN);
        end
    endtask

    task automatic test_level_idle();
        int n_low = 0;
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.led !== 1'b1) begin
            failures++;
            $display("FAIL level_follow: got %b expected 1", bus.led);
        end
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick(1'b0, 1'b1, 1'b0);
            n_low += int'(!bus.led);
            checks++;
            if (w_act !== m_exp) begin
                failures++;
                $display("FAIL level_blink cyc%0d: got %b expected %b", i, w_act, m_exp);
            end
        end
        checks++;
        if (n_low != ON) begin
            failures++;
            $display("FAIL level_low_count: got %0d expected %0d", n_low, ON);
        end
    endtask

    task automatic test_back_to_back();
        int n_busy = 0;
        tick(1'b1, 1'b0, 1'b0);
        n_busy += int'(bus.busy);
        tick(1'b1, 1'b0, 1'b0);
        n_busy += int'(bus.busy);
        tick(1'b1, 1'b0, 1'b0);
        n_busy += int'(bus.busy);
        checks++;
        if (bus.pending !== 2'd2) begin
            failures++;
            $display("FAIL b2b_pending: got %0d expected 2", bus.pending);
        end
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_busy += int'(bus.busy);
            checks++;
            if (w_act !== m_exp) begin
                failures++;
                $display("FAIL b2b cyc%0d: got %b expected %b", i, w_act, m_exp);
            end
        end
        checks++;
        if (n_busy != 3 * LEN || bus.pending !== 2'd0) begin
            failures++;
            $display("FAIL b2b_totals: got busy=%0d pending=%0d expected %0d 0",
                     n_busy, bus.pending, 3 * LEN);
        end
    endtask

    task automatic test_saturation();
        int n_done = 0;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.pending !== 2'd3 || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL sat: got pending=%0d ovf=%b expected 3 1", bus.pending, bus.overflow);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_done += int'(bus.blink_done);
            checks++;
            if (w_act !== m_exp) begin
                failures++;
                $display("FAIL sat cyc%0d: got %b expected %b", i, w_act, m_exp);
            end
        end
        checks++;
        if (n_done != 4 || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL sat_totals: got done=%0d ovf=%b expected 4 1", n_done, bus.overflow);
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_off_end_edge();
        bit hit = 0;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_active && m_pos == LEN - 1) begin
                hit = 1;
                tick(1'b1, 1'b0, 1'b0);
            end else begin
                tick(1'b0, 1'b0, 1'b0);
            end
        end
        checks++;
        if (!hit || bus.pending !== 2'd1 || bus.led !== 1'b1 || bus.blink_done !== 1'b1) begin
            failures++;
            $display("FAIL off_end: got hit=%b pending=%0d led=%b done=%b expected 1 1 1 1",
                     hit, bus.pending, bus.led, bus.blink_done);
        end
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (w_act !== m_exp) begin
                failures++;
                $display("FAIL off_end_drain cyc%0d: got %b expected %b", i, w_act, m_exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.led !== 1'b0 || bus.pending !== 2'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got led=%b pending=%0d busy=%b expected 0 0 0",
                     bus.led, bus.pending, bus.busy);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.led !== 1'b0 || bus.busy !== 1'b0 || w_act !== m_exp) begin
                failures++;
                $display("FAIL reset_mid_idle cyc%0d: got %b expected %b", i, w_act, m_exp);
            end
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) lvl = ~lvl;
            tick(logic'($urandom_range(0, 3) == 0), lvl, logic'($urandom_range(0, 199) == 0));
            checks++;
            if (w_act !== m_exp) begin
                failures++;
                $display("FAIL random cyc%0d: got %b expected %b", i, w_act, m_exp);
            end
        end
    endtask

    initial begin
        bus.event_pulse = 1'b0;
        bus.level_in    = 1'b0;
        #1;
        test_reset();
        test_single_blink();
        test_level_idle();
        tick(1'b0, 1'b0, 1'b0);
        test_back_to_back();
        test_saturation();
        test_off_end_edge();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
